// File: rtl/simon_sequence_gen_pkg.sv
// Shared types and constants for the Simon Says sequence generator.
// Build option: SEQ_NO_REPEAT_EN (see simon_sequence_gen.sv).
package simon_pkg;

  localparam int          MAX_LEN_DEFAULT = 16;
  localparam logic [15:0] LFSR_MASK       = 16'hB400;

  typedef enum logic [1:0] {
    RED    = 2'd0,
    GREEN  = 2'd1,
    BLUE   = 2'd2,
    YELLOW = 2'd3
  } color_t;

  typedef enum logic [4:0] {
    IDLE     = 5'b00001,
    CLEAR    = 5'b00010,
    APPEND   = 5'b00100,
    ANNOUNCE = 5'b01000,
    READY    = 5'b10000
  } seq_state_t;

  // One step of the right-shifting Galois LFSR.
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? LFSR_MASK : 16'h0000);
  endfunction

endpackage

// File: rtl/simon_sequence_gen_if.sv
// Request/response bundle between the game controller and the sequence generator.
interface simon_sequence_gen_if
  import simon_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEFAULT
) ();

  localparam int LW = $clog2(MAX_LEN + 1);

  // new_game/add_color are one-cycle request pulses; there is no back-pressure,
  // so a request seen while busy is high is dropped. display_start pulses for one
  // cycle when Colors/seq_len hold a complete new round, and they stay stable until
  // the next accepted request.
  logic                 new_game;
  logic                 add_color;
  logic [2*MAX_LEN-1:0] Colors;
  logic [LW-1:0]        seq_len;
  logic                 display_start;
  logic                 busy;
  logic                 full;

  modport master (
    output new_game, add_color,
    input  Colors, seq_len, display_start, busy, full
  );

  modport slave (
    input  new_game, add_color,
    output Colors, seq_len, display_start, busy, full
  );

endinterface

// File: rtl/simon_lfsr16.sv
// Free-running 16-bit Galois LFSR; a zero seed is replaced by 1 so it never locks up.
module simon_lfsr16
  import simon_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] value
);

  localparam logic [15:0] SAFE_SEED = (SEED == 16'h0000) ? 16'h0001 : SEED;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) value <= SAFE_SEED;
    else       value <= lfsr_step(value);
  end

endmodule

// File: rtl/simon_sequence_gen.sv
// Builds the growing packed color sequence and announces each new round.
// Build option: SEQ_NO_REPEAT_EN bumps a color that would repeat its predecessor.
module simon_sequence_gen
  import simon_pkg::*;
#(
  parameter int          MAX_LEN   = MAX_LEN_DEFAULT,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                 clk,
  input  logic                 reset,
  simon_sequence_gen_if.slave  bus,
  output seq_state_t           dbg_state
);

  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int CW = 2 * MAX_LEN;

  seq_state_t     state, next_state;
  logic [15:0]    lfsr;
  logic [CW-1:0]  colors_q;
  logic [LW-1:0]  len_q;
  logic           full_q;
  logic [1:0]     color_d;
  logic           lfsr_unused;

  simon_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .value (lfsr)
  );

  assign lfsr_unused = ^lfsr[15:2];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // new_game overrides everything except the mandatory CLEAR->APPEND step.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:     if (bus.new_game) next_state = CLEAR;
      CLEAR:    next_state = APPEND;
      APPEND:   next_state = bus.new_game ? CLEAR : ANNOUNCE;
      ANNOUNCE: next_state = bus.new_game ? CLEAR : READY;
      READY: begin
        if (bus.new_game)                    next_state = CLEAR;
        else if (bus.add_color && !full_q)   next_state = APPEND;
      end
      default:  next_state = IDLE;
    endcase
  end

`ifdef SEQ_NO_REPEAT_EN
  logic [CW-1:0] prev_word;
  logic [1:0]    prev;
  always_comb begin
    prev_word = '0;
    if (len_q != '0) prev_word = colors_q >> ({len_q, 1'b0} - 2);
    prev    = prev_word[1:0];
    color_d = lfsr[1:0];
    if (len_q != '0 && lfsr[1:0] == prev) color_d = lfsr[1:0] + 2'd1;
  end
`else
  always_comb begin
    color_d = lfsr[1:0];
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      colors_q <= '0;
      len_q    <= '0;
      full_q   <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          colors_q <= '0;
          len_q    <= '0;
          full_q   <= 1'b0;
        end
        APPEND: begin
          if (len_q < LW'(MAX_LEN)) begin
            colors_q <= colors_q | ({{(CW-2){1'b0}}, color_d} << {len_q, 1'b0});
            len_q    <= len_q + 1'b1;
            full_q   <= (len_q == LW'(MAX_LEN - 1));
          end
        end
        default: ;
      endcase
    end
  end

  // Moore outputs straight from state so reset clears them without waiting for a clock.
  assign bus.display_start = (state == ANNOUNCE);
  assign bus.busy          = (state == CLEAR) || (state == APPEND) || (state == ANNOUNCE);
  assign bus.Colors        = colors_q;
  assign bus.seq_len       = len_q;
  assign bus.full          = full_q;
  assign dbg_state         = state;

endmodule

// File: tb/tb_simon_sequence_gen.sv
// Directed + randomized-gap bench for simon_sequence_gen, two instances (default seed and zero seed).
module tb_simon_sequence_gen;
  import simon_pkg::*;

  localparam int          ML    = 16;
  localparam logic [15:0] SEED0 = 16'hACE1;
  localparam logic [15:0] SEED1 = 16'h0001;

  logic       clk = 1'b0;
  logic       reset;
  seq_state_t st0, st1;

  int compared   = 0;
  int mismatched = 0;

  logic [15:0] m0, m1;
  logic [1:0]  exp0_q[$];
  logic [1:0]  exp1_q[$];

  always #5 clk = ~clk;

  simon_sequence_gen_if #(.MAX_LEN(ML)) bus0 ();
  simon_sequence_gen_if #(.MAX_LEN(ML)) bus1 ();

  simon_sequence_gen #(.MAX_LEN(ML), .LFSR_SEED(SEED0)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0), .dbg_state(st0));
  simon_sequence_gen #(.MAX_LEN(ML), .LFSR_SEED(16'h0000)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1), .dbg_state(st1));

  function automatic logic [15:0] galois(input logic [15:0] x);
    logic [15:0] r;
    r = x / 2;
    if (x % 2 == 1) r = r ^ 16'hB400;
    return r;
  endfunction

  function automatic logic [2*ML-1:0] pack(input logic [1:0] q[$]);
    logic [2*ML-1:0] r;
    r = '0;
    foreach (q[i]) r[2*i +: 2] = q[i];
    return r;
  endfunction

  function automatic logic [1:0] model_color(input logic [1:0] raw, input logic [1:0] q[$]);
`ifdef SEQ_NO_REPEAT_EN
    if (q.size() > 0 && q[q.size()-1] == raw) return 2'((raw + 1) % 4);
`endif
    return raw;
  endfunction

  task automatic tick();
    @(posedge clk);
    if (!reset) begin
      m0 = galois(m0);
      m1 = galois(m1);
    end
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic ds, input logic bsy);
    chk({tag, ".ds0"},   32'(bus0.display_start), 32'(ds));
    chk({tag, ".busy0"}, 32'(bus0.busy),          32'(bsy));
    chk({tag, ".len0"},  32'(bus0.seq_len),       32'(exp0_q.size()));
    chk({tag, ".col0"},  bus0.Colors,             pack(exp0_q));
    chk({tag, ".full0"}, 32'(bus0.full),          32'(exp0_q.size() == ML));
    chk({tag, ".ds1"},   32'(bus1.display_start), 32'(ds));
    chk({tag, ".busy1"}, 32'(bus1.busy),          32'(bsy));
    chk({tag, ".len1"},  32'(bus1.seq_len),       32'(exp1_q.size()));
    chk({tag, ".col1"},  bus1.Colors,             pack(exp1_q));
    chk({tag, ".full1"}, 32'(bus1.full),          32'(exp1_q.size() == ML));
  endtask

  task automatic drive(input logic ng, input logic ac);
    bus0.new_game = ng; bus0.add_color = ac;
    bus1.new_game = ng; bus1.add_color = ac;
  endtask

  task automatic new_game_round(input string tag, input logic with_add, input int gap);
    drive(1'b1, with_add);
    tick();                        // CLEAR
    drive(1'b0, 1'b0);
    check_all({tag, ".clr"}, 1'b0, 1'b1);
    tick();                        // APPEND
    exp0_q.delete();
    exp1_q.delete();
    check_all({tag, ".app"}, 1'b0, 1'b1);
    exp0_q.push_back(model_color(m0[1:0], exp0_q));
    exp1_q.push_back(model_color(m1[1:0], exp1_q));
    tick();                        // ANNOUNCE
    check_all({tag, ".ann"}, 1'b1, 1'b1);
    tick();
    check_all({tag, ".rdy"}, 1'b0, 1'b0);
    repeat (gap) tick();
  endtask

  task automatic add_round(input string tag, input int gap);
    drive(1'b0, 1'b1);
    tick();                        // APPEND
    drive(1'b0, 1'b0);
    check_all({tag, ".app"}, 1'b0, 1'b1);
    exp0_q.push_back(model_color(m0[1:0], exp0_q));
    exp1_q.push_back(model_color(m1[1:0], exp1_q));
    tick();                        // ANNOUNCE
    check_all({tag, ".ann"}, 1'b1, 1'b1);
    tick();
    check_all({tag, ".rdy"}, 1'b0, 1'b0);
    repeat (gap) tick();
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 1'b0);
    m0 = SEED0;
    m1 = SEED1;
    repeat (3) tick();
    check_all("reset", 1'b0, 1'b0);
    reset = 1'b0;

    // add_color in IDLE has no effect
    tick();
    drive(1'b0, 1'b1);
    tick();
    drive(1'b0, 1'b0);
    check_all("idle_add", 1'b0, 1'b0);
    tick();
    check_all("idle_add2", 1'b0, 1'b0);
    tick();

    new_game_round("ng1", 1'b0, 6);
    for (int i = 0; i < ML - 1; i++) add_round($sformatf("add%0d", i), 7);
    chk("full_len", 32'(bus0.seq_len), 32'(ML));
    chk("full_flag", 32'(bus0.full), 32'd1);

    // request while full is ignored
    drive(1'b0, 1'b1);
    tick();
    drive(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check_all($sformatf("full_ign%0d", i), 1'b0, 1'b0);
      tick();
    end

    // build to 7 colors with random player timing, then collide new_game with add_color
    new_game_round("ng2", 1'b0, $urandom_range(0, 6));
    for (int i = 0; i < 6; i++) add_round($sformatf("r7_%0d", i), $urandom_range(0, 9));
    chk("len7", 32'(bus0.seq_len), 32'd7);
    new_game_round("ng_both", 1'b1, 2);

    // second request during APPEND is dropped; reset during ANNOUNCE
    drive(1'b0, 1'b1);
    tick();                        // APPEND, add_color still high
    check_all("drop.app", 1'b0, 1'b1);
    exp0_q.push_back(model_color(m0[1:0], exp0_q));
    exp1_q.push_back(model_color(m1[1:0], exp1_q));
    tick();                        // ANNOUNCE
    drive(1'b0, 1'b0);
    check_all("drop.ann", 1'b1, 1'b1);
    #2;
    reset = 1'b1;
    m0 = SEED0;
    m1 = SEED1;
    exp0_q.delete();
    exp1_q.delete();
    #1;
    check_all("async_rst", 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      tick();
      check_all($sformatf("rst_hold%0d", i), 1'b0, 1'b0);
    end
    reset = 1'b0;
    tick();
    check_all("rst_rel", 1'b0, 1'b0);

    // eight rounds with random spacing; dut1 starts from the sanitised seed 1
    new_game_round("ng3", 1'b0, $urandom_range(0, 5));
    for (int i = 0; i < 7; i++) add_round($sformatf("r8_%0d", i), $urandom_range(0, 5));
`ifdef SEQ_NO_REPEAT_EN
    for (int i = 1; i < exp1_q.size(); i++) begin
      chk($sformatf("norep1_%0d", i),
          32'(bus1.Colors[2*i +: 2] != bus1.Colors[2*(i-1) +: 2]), 32'd1);
      chk($sformatf("norep0_%0d", i),
          32'(bus0.Colors[2*i +: 2] != bus0.Colors[2*(i-1) +: 2]), 32'd1);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/simon_sequence_gen.md
# simon_sequence_gen

Upstream stage of the Simon Says datapath. Builds the growing random color sequence the player must repeat, packed two bits per color into the 32-bit word consumed by the color display stage, and tells that stage when a new round is ready. A free-running 16-bit LFSR supplies the colors; player timing between requests provides the entropy.

## Interface

Parameters:
- MAX_LEN, 16, maximum sequence length in colors. The packed output is 2*MAX_LEN bits wide, which is 32 at the default.
- LFSR_SEED, 16'hACE1, LFSR value loaded at reset. A value of 0 is replaced by 16'h0001.

Ports:
- clk  input  1  system clock. All state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- new_game  input  1  single-cycle pulse. Clears the sequence and appends the first color.
- add_color  input  1  single-cycle pulse. Appends one color for the next round.
- Colors  output  2*MAX_LEN  packed sequence. Color k occupies bits [2k+1:2k]. Unused slots are 0.
- seq_len  output  $clog2(MAX_LEN+1)  number of valid colors.
- display_start  output  1  single-cycle pulse. Colors and seq_len are stable and hold a new round.
- busy  output  1  the block is updating the sequence. Requests arriving while it is high are dropped.
- full  output  1  seq_len == MAX_LEN.

## Operation

- The FSM is Moore and one-hot. Its states are IDLE, CLEAR, APPEND, ANNOUNCE and READY.
- IDLE: the reset state. add_color is ignored. new_game moves to CLEAR.
- CLEAR: Colors and seq_len are set to 0. Always moves to APPEND.
- APPEND: writes the color into slot seq_len and increments seq_len. Always moves to ANNOUNCE.
  - The color is lfsr[1:0], as modified by the configuration option below.
- ANNOUNCE: display_start = 1. Always moves to READY.
- READY: waits for a request.
  - new_game moves to CLEAR.
  - add_color with full = 0 moves to APPEND.
  - add_color with full = 1 is ignored. The state stays READY and display_start stays low.
- new_game from any state (IDLE, APPEND, ANNOUNCE, READY) forces CLEAR on the next edge. It aborts an in-progress APPEND or ANNOUNCE, and no display_start is issued for the aborted round.
- new_game and add_color in the same cycle: new_game wins and add_color is dropped.
- busy = 1 in CLEAR, APPEND and ANNOUNCE. add_color received while busy is dropped, not queued.
- LFSR: 16-bit Galois, shifting right, with feedback mask 16'hB400. It advances every cycle, including in IDLE, and is never reset by new_game.
- Reset values:
  - state = IDLE.
  - Colors = 0, seq_len = 0.
  - display_start = 0, busy = 0, full = 0.
  - lfsr = LFSR_SEED (0 replaced by 1).
- Reset asserted mid-operation returns every output to its reset value immediately (asynchronously). No display_start is issued.

## Timing

- A request sampled at the edge ending cycle N puts the block in CLEAR or APPEND during N+1.
- For add_color: Colors and seq_len update at the edge ending N+1. display_start is high during N+2. busy is high during N+1 and N+2.
- For new_game: CLEAR in N+1, APPEND in N+2, display_start in N+3 with seq_len = 1. busy is high during N+1 through N+3.
- The color written is the lfsr[1:0] value present during the APPEND cycle.
- Colors and seq_len change only at the edge leaving CLEAR or APPEND. They hold otherwise.

## Configuration

- SEQ_NO_REPEAT_EN defined: when seq_len > 0 and lfsr[1:0] equals color seq_len-1, the stored color is (lfsr[1:0] + 1) mod 4. The same color is never shown twice in a row.
- SEQ_NO_REPEAT_EN undefined: lfsr[1:0] is stored unmodified, and consecutive repeats are allowed.

## Structure

- Package simon_pkg holds:
  - color_t, a 2-bit enum: RED = 0, GREEN = 1, BLUE = 2, YELLOW = 3.
  - seq_state_t, the FSM state enum.
  - LFSR_MASK = 16'hB400.
  - MAX_LEN_DEFAULT = 16.
- Sub-module simon_lfsr16 contains the free-running LFSR and its seed-sanitising logic. Its ports are clk, reset and a 16-bit value output.

## Test plan

- Reset, then new_game in cycle 5:
  - Required: busy is high for cycles 6–8, display_start is high in cycle 8, seq_len = 1.
  - Required: Colors[1:0] equals the reference LFSR model's lfsr[1:0] in cycle 7, and Colors[31:2] = 0.
- 15 add_color pulses spaced 10 cycles apart after new_game:
  - Required: seq_len reaches 16 and full = 1.
  - Required: each display_start follows its request by exactly 2 cycles.
  - Required: all 16 slots match the model.
- A 17th add_color while full:
  - Required: no display_start, and Colors and seq_len are unchanged.
- new_game and add_color together in READY with seq_len = 7:
  - Required: CLEAR occurs and the following display_start reports seq_len = 1.
- add_color during APPEND, then reset asserted during ANNOUNCE:
  - Required: the first request is dropped (seq_len increments by 1 only).
  - Required: on reset, outputs go to 0 immediately and no display_start pulse appears.
- With SEQ_NO_REPEAT_EN: force the LFSR model to yield a repeat (seed 16'h0001, seeding 8 rounds).
  - Required: no two adjacent slots are equal.
  - Without the macro, the same run matches the raw LFSR values.
